// File: rtl/i2c_wb_if_pkg.sv
// Shared types and constants for the i2c_wb_if Wishbone-controlled I2C target.
package i2c_wb_if_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWr,
    StWrAck,
    StRd,
    StRdAck,
    StIgnore
  } i2c_state_e;

  // Wishbone register map
  localparam logic [1:0] RegCsr  = 2'd0;
  localparam logic [1:0] RegSadr = 2'd1;
  localparam logic [1:0] RegTxd  = 2'd2;
  localparam logic [1:0] RegRxd  = 2'd3;

  // CSR bit positions
  localparam int unsigned CsrEn   = 7;
  localparam int unsigned CsrIe   = 6;
  localparam int unsigned CsrBusy = 5;
  localparam int unsigned CsrIrq  = 4;
  localparam int unsigned CsrRxv  = 3;
  localparam int unsigned CsrOvr  = 2;

  // Register reset values
  localparam logic [7:0] CSR_RST  = 8'h00;
  localparam logic [7:0] SADR_RST = 8'h22;
  localparam logic [7:0] TXD_RST  = 8'h00;
  localparam logic [7:0] RXD_RST  = 8'h00;

  // 2-of-3 majority vote used by the optional glitch filter
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_wb_if_sync.sv
// SCL/SDA input conditioning: 2-flop synchronizer, optional 3-sample majority
// filter (I2C_WB_IF_GLITCH_FILTER_EN), and SCL edge / START / STOP detection.
module i2c_wb_if_sync
  import i2c_wb_if_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_s, sda_s;

`ifdef I2C_WB_IF_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, scl_hist_d;
  logic [1:0] sda_hist_q, sda_hist_d;
  logic       scl_filt_q, scl_filt_d;
  logic       sda_filt_q, sda_filt_d;

  // Majority vote over the synchronized sample and its two predecessors
  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
    scl_filt_d = maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
    sda_filt_d = maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
  end

  // Filter state; idle bus is high
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  // Synchronizer shift and previous-level capture for edge detection
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Synchronizer and history flops; reset to the idle (released) level
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_lvl_o  = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SDA may only move while SCL is high across both samples for START/STOP
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_wb_if.sv
// Wishbone B4 classic slave with four registers fronting an I2C target.
// Optional input glitch filter: define I2C_WB_IF_GLITCH_FILTER_EN.
module i2c_wb_if
  import i2c_wb_if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned I2C_ADDR_WIDTH = 7,
  parameter int unsigned I2C_DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o
);

  localparam logic [3:0] ByteBits = 4'(I2C_DATA_WIDTH);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_wb_if_sync u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_lvl_o  (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  // Wishbone side state
  logic                      ack_q, ack_d;
  logic [DATA_WIDTH-1:0]     dat_o_q, dat_o_d;
  logic                      en_q, en_d, ie_q, ie_d;
  logic                      irq_q, irq_d, rxv_q, rxv_d, ovr_q, ovr_d;
  logic [I2C_ADDR_WIDTH-1:0] sadr_q, sadr_d;
  logic [DATA_WIDTH-1:0]     txd_q, txd_d, rxd_q, rxd_d;

  // I2C side state
  i2c_state_e                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [I2C_DATA_WIDTH-1:0] sh_q, sh_d;
  logic                      rw_q, rw_d, nack_q, nack_d;
  logic                      sda_o_q, sda_o_d;
  logic                      busy_q, busy_d, addressed_q, addressed_d;
  logic                      rx_evt, irq_set;

  logic wb_req, wb_wr, wb_rd;
  logic [7:0] csr_rd;

  assign wb_req = cyc_i & stb_i & ~ack_q;
  assign wb_wr  = wb_req & we_i;
  assign wb_rd  = wb_req & ~we_i;
  assign csr_rd = {en_q, ie_q, busy_q, irq_q, rxv_q, ovr_q, 2'b00};

  // EN/IE kept apart so the FSM can react to EN in the same edge as the write
  always_comb begin
    en_d = en_q;
    ie_d = ie_q;
    if (wb_wr && adr_i == RegCsr) begin
      en_d = dat_i[CsrEn];
      ie_d = dat_i[CsrIe];
    end
  end

  // Register writes, read-clear of RXV, then hardware sets which take priority
  always_comb begin
    irq_d  = irq_q;
    rxv_d  = rxv_q;
    ovr_d  = ovr_q;
    sadr_d = sadr_q;
    txd_d  = txd_q;
    rxd_d  = rxd_q;
    if (wb_wr) begin
      case (adr_i)
        RegCsr: begin
          if (dat_i[CsrIrq]) irq_d = 1'b0;
          if (dat_i[CsrOvr]) ovr_d = 1'b0;
        end
        RegSadr: sadr_d = dat_i[I2C_ADDR_WIDTH-1:0];
        RegTxd:  txd_d  = dat_i;
        default: ;
      endcase
    end
    if (wb_rd && adr_i == RegRxd) rxv_d = 1'b0;
    if (rx_evt) begin
      rxd_d = DATA_WIDTH'(sh_q);
      rxv_d = 1'b1;
      if (rxv_q) ovr_d = 1'b1;
    end
    if (irq_set) irq_d = 1'b1;
  end

  // One-cycle ack and registered read data (zero outside an acked read)
  always_comb begin
    ack_d   = wb_req;
    dat_o_d = '0;
    if (wb_rd) begin
      case (adr_i)
        RegCsr:  dat_o_d = DATA_WIDTH'(csr_rd);
        RegSadr: dat_o_d = DATA_WIDTH'(sadr_q);
        RegTxd:  dat_o_d = txd_q;
        default: dat_o_d = rxd_q;
      endcase
    end
  end

  // Wishbone-side registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q   <= 1'b0;
      dat_o_q <= '0;
      en_q    <= CSR_RST[CsrEn];
      ie_q    <= CSR_RST[CsrIe];
      irq_q   <= CSR_RST[CsrIrq];
      rxv_q   <= CSR_RST[CsrRxv];
      ovr_q   <= CSR_RST[CsrOvr];
      sadr_q  <= I2C_ADDR_WIDTH'(SADR_RST);
      txd_q   <= DATA_WIDTH'(TXD_RST);
      rxd_q   <= DATA_WIDTH'(RXD_RST);
    end else begin
      ack_q   <= ack_d;
      dat_o_q <= dat_o_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
      rxv_q   <= rxv_d;
      ovr_q   <= ovr_d;
      sadr_q  <= sadr_d;
      txd_q   <= txd_d;
      rxd_q   <= rxd_d;
    end
  end

  // I2C target next state: bits sampled on SCL rise, SDA driven after SCL fall
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    sda_o_d     = sda_o_q;
    busy_d      = busy_q;
    addressed_d = addressed_q;
    rx_evt      = 1'b0;
    irq_set     = 1'b0;
    if (!en_d) begin
      state_d     = StIdle;
      sda_o_d     = 1'b1;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
    end else if (stop_det) begin
      state_d     = StIdle;
      sda_o_d     = 1'b1;
      busy_d      = 1'b0;
      irq_set     = addressed_q;
      addressed_d = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = '0;
      sda_o_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: ;
        StAddr: begin
          if (scl_rise) begin
            sh_d  = {sh_q[I2C_DATA_WIDTH-2:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == ByteBits) begin
            cnt_d = '0;
            if (sh_q[I2C_ADDR_WIDTH:1] == sadr_q) begin
              state_d     = StAddrAck;
              sda_o_d     = 1'b0;
              rw_d        = sh_q[0];
              busy_d      = 1'b1;
              addressed_d = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d = StRd;
              sh_d    = I2C_DATA_WIDTH'(txd_q);
              sda_o_d = txd_q[DATA_WIDTH-1];
            end else begin
              state_d = StWr;
              sda_o_d = 1'b1;
            end
          end
        end
        StWr: begin
          if (scl_rise) begin
            sh_d  = {sh_q[I2C_DATA_WIDTH-2:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == ByteBits) begin
            rx_evt  = 1'b1;
            state_d = StWrAck;
            sda_o_d = 1'b0;
            cnt_d   = '0;
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            state_d = StWr;
            sda_o_d = 1'b1;
          end
        end
        StRd: begin
          // MSB already on the bus; each fall presents the next bit
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == ByteBits) begin
              state_d = StRdAck;
              sda_o_d = 1'b1;
              cnt_d   = '0;
            end else begin
              sda_o_d = sh_q[I2C_DATA_WIDTH-2];
              sh_d    = {sh_q[I2C_DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            nack_d = sda_s;
          end else if (scl_fall) begin
            if (nack_q) begin
              state_d = StIgnore;
              sda_o_d = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = StRd;
              sh_d    = I2C_DATA_WIDTH'(txd_q);
              sda_o_d = txd_q[DATA_WIDTH-1];
              cnt_d   = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // I2C FSM state and registered SDA drive
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_q        <= '0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      sda_o_q     <= 1'b1;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      sda_o_q     <= sda_o_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_o_q;
  assign sda_o = sda_o_q;
  assign irq_o = irq_q & ie_q;

endmodule

// File: tb/tb_i2c_wb_if.sv
// Directed bench for i2c_wb_if: Wishbone register access plus a simple
// bit-banged I2C master on an open-drain SDA wire.
module tb_i2c_wb_if;

  localparam int Q = 6;  // quarter of an SCL period in clk_i cycles

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] dat_w, dat_r;
  logic       ack_o, irq_o;
  logic       scl, m_sda;
  logic       sda_o_w;
  wire        sda_bus;

  int n_checks = 0;
  int n_errors = 0;

  assign sda_bus = m_sda & sda_o_w;

  always #5 clk_i = ~clk_i;

  i2c_wb_if dut (
    .clk_i (clk_i),
    .rst_i (rst_n),
    .cyc_i (cyc),
    .stb_i (stb),
    .we_i  (we),
    .adr_i (adr),
    .dat_i (dat_w),
    .dat_o (dat_r),
    .ack_o (ack_o),
    .irq_o (irq_o),
    .scl_i (scl),
    .sda_i (sda_bus),
    .sda_o (sda_o_w)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    logic got;
    @(posedge clk_i); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk_i); #1;
      got = ack_o;
    end
    q = dat_r;
    check_val("wb_ack", 8'(ack_o), 8'h01);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk_i); #1;
    check_val("wb_ack_pulse", 8'(ack_o), 8'h00);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] q;
    wb_xfer(1'b0, a, 8'h00, q);
    check_val(tag, q, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; hold(Q);
    scl = 1'b1;   hold(2 * Q);
    m_sda = 1'b0; hold(2 * Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    hold(Q); m_sda = 1'b0;
    hold(Q); scl = 1'b1;
    hold(2 * Q); m_sda = 1'b1;
    hold(2 * Q);
  endtask

  task automatic i2c_bit_out(input logic b);
    hold(Q); m_sda = b;
    hold(Q); scl = 1'b1;
    hold(2 * Q); scl = 1'b0;
  endtask

  task automatic i2c_bit_in(output logic b);
    m_sda = 1'b1;
    hold(2 * Q); scl = 1'b1;
    hold(Q); b = sda_bus;
    hold(Q); scl = 1'b0;
  endtask

  task automatic i2c_write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit_out(d[i]);
    i2c_bit_in(ack);
  endtask

  task automatic i2c_read_byte(output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      i2c_bit_in(b);
      d = {d[6:0], b};
    end
  endtask

  // Hard stop if something wedges the run
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic [7:0] addr_w;
    addr_w = 8'h44;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_w = 8'h00;
    scl = 1'b1; m_sda = 1'b1;

    // Reset state
    hold(4);
    check_val("rst_ack", 8'(ack_o), 8'h00);
    check_val("rst_dat", dat_r, 8'h00);
    check_val("rst_irq", 8'(irq_o), 8'h00);
    check_val("rst_sda", 8'(sda_o_w), 8'h01);
    @(posedge clk_i); #1 rst_n = 1'b1;
    hold(2);
    check_val("post_rst_sda", 8'(sda_o_w), 8'h01);
    check_val("post_rst_irq", 8'(irq_o), 8'h00);
    wb_read_chk("rst_csr", 2'd0, 8'h00);
    wb_read_chk("rst_sadr", 2'd1, 8'h22);
    wb_read_chk("rst_txd", 2'd2, 8'h00);
    wb_read_chk("rst_rxd", 2'd3, 8'h00);

    // Master write 0x5A to own address
    wb_write(2'd0, 8'hC0);
    i2c_start();
    i2c_write_byte(8'h44, ack);
    check_val("wr_addr_ack", 8'(ack), 8'h00);
    i2c_write_byte(8'h5A, ack);
    check_val("wr_data_ack", 8'(ack), 8'h00);
    i2c_stop();
    check_val("wr_irq_o", 8'(irq_o), 8'h01);
    wb_read_chk("wr_csr", 2'd0, 8'hD8);
    wb_read_chk("wr_rxd", 2'd3, 8'h5A);
    wb_read_chk("rxv_cleared", 2'd0, 8'hD0);

    // Clear IRQ
    wb_write(2'd0, 8'hD0);
    check_val("irq_cleared", 8'(irq_o), 8'h00);
    wb_read_chk("csr_after_clr", 2'd0, 8'hC0);

    // Master read two bytes: ACK then NACK
    wb_write(2'd2, 8'hA5);
    wb_read_chk("txd_rb", 2'd2, 8'hA5);
    i2c_start();
    i2c_write_byte(8'h45, ack);
    check_val("rd_addr_ack", 8'(ack), 8'h00);
    i2c_read_byte(rd);
    check_val("rd_byte0", rd, 8'hA5);
    i2c_bit_out(1'b0);
    i2c_read_byte(rd);
    check_val("rd_byte1", rd, 8'hA5);
    i2c_bit_out(1'b1);
    hold(2 * Q);
    check_val("nack_sda_rel", 8'(sda_o_w), 8'h01);
    i2c_stop();
    check_val("rd_irq_o", 8'(irq_o), 8'h01);
    wb_write(2'd0, 8'hD0);
    check_val("rd_irq_clr", 8'(irq_o), 8'h00);

    // Foreign address 0x23: no ACK, no IRQ, RXD kept
    i2c_start();
    i2c_write_byte(8'h46, ack);
    check_val("foreign_nack", 8'(ack), 8'h01);
    i2c_stop();
    check_val("foreign_irq", 8'(irq_o), 8'h00);
    wb_read_chk("foreign_csr", 2'd0, 8'hC0);
    wb_read_chk("foreign_rxd", 2'd3, 8'h5A);

    // Two bytes back to back -> overrun; repeated START re-addresses
    i2c_start();
    i2c_write_byte(8'h44, ack);
    check_val("ovr_addr_ack", 8'(ack), 8'h00);
    wb_read_chk("busy_csr", 2'd0, 8'hE0);
    i2c_write_byte(8'h11, ack);
    check_val("ovr_b0_ack", 8'(ack), 8'h00);
    i2c_write_byte(8'h22, ack);
    check_val("ovr_b1_ack", 8'(ack), 8'h00);
    i2c_start();
    i2c_write_byte(8'h44, ack);
    check_val("rs_addr_ack", 8'(ack), 8'h00);
    i2c_stop();
    wb_read_chk("ovr_csr", 2'd0, 8'hDC);
    wb_read_chk("ovr_rxd", 2'd3, 8'h22);
    wb_write(2'd0, 8'hD4);
    wb_read_chk("ovr_clr_csr", 2'd0, 8'hC0);

    // EN=0 mid-ACK releases SDA at once and suppresses the IRQ
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit_out(addr_w[i]);
    hold(Q);
    check_val("ack_drive_low", 8'(sda_o_w), 8'h00);
    wb_write(2'd0, 8'h40);
    check_val("dis_sda_rel", 8'(sda_o_w), 8'h01);
    i2c_bit_in(ack);
    check_val("dis_no_ack", 8'(ack), 8'h01);
    i2c_stop();
    check_val("dis_irq", 8'(irq_o), 8'h00);
    wb_read_chk("dis_csr", 2'd0, 8'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_wb_if.md
# i2c_wb_if

Wishbone-controlled I2C target (slave) with a four-register Wishbone B4 classic slave port and an open-drain I2C SDA interface. It answers an I2C master, such as the iicmb controller, on one bus. It captures bytes the master writes and returns a software-loaded byte on master reads. It raises an interrupt at the end of each addressed transaction.

## Interface
- ADDR_WIDTH, 2, Wishbone register address width
- DATA_WIDTH, 8, Wishbone data width
- I2C_ADDR_WIDTH, 7, I2C target address width
- I2C_DATA_WIDTH, 8, I2C byte width
- clk_i  in  1  system clock; all logic rises on clk_i
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low
- cyc_i  in  1  Wishbone valid cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  1=write, 0=read
- adr_i  in  ADDR_WIDTH  register select
- dat_i  in  DATA_WIDTH  write data
- dat_o  out  DATA_WIDTH  read data, valid with ack_o
- ack_o  out  1  one-cycle acknowledge
- irq_o  out  1  level interrupt
- scl_i  in  1  I2C clock; the target never drives SCL
- sda_i  in  1  I2C data sampled from the bus
- sda_o  out  1  open-drain drive; 0 pulls low, 1 releases

## Operation
- Registers:
  - 0 CSR:
    - [7] EN, RW
    - [6] IE, RW
    - [5] BUSY, RO, set from own-address ACK to STOP or NACK
    - [4] IRQ, write 1 to clear
    - [3] RXV, RO
    - [2] OVR, write 1 to clear
    - [1:0] read 0
  - 1 SADR: [6:0] target address, bit 7 reads 0
  - 2 TXD: byte returned to the master on reads, RW
  - 3 RXD: last byte written by the master, RO; a Wishbone read clears RXV
- Register reset values: CSR 0x00, SADR 0x22, TXD 0x00, RXD 0x00.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are evaluated on synchronized signals.
- Bits are sampled on the SCL rising edge, MSB first. sda_o changes only after the SCL falling edge is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
  - IDLE -START-> ADDR.
  - ADDR collects 7 address bits plus R/W. On address match go to ADDR_ACK and drive 0 for one SCL period. On mismatch go to IGNORE.
  - After ADDR_ACK: W=0 goes to WR, R=1 goes to RD.
  - WR: after 8 bits, RXD = byte and RXV = 1. If RXV was already 1, set OVR and overwrite RXD. The target always ACKs in WR_ACK, then returns to WR.
  - RD shifts out TXD. RD_ACK samples the master's ACK bit. ACK (0) sends TXD again. NACK (1) goes to IGNORE with SDA released.
  - START in any state goes to ADDR (repeated start). STOP in any state goes to IDLE.
  - A STOP that ends an addressed transaction sets IRQ.
- EN=0 forces IDLE and sda_o=1 immediately, including mid-transaction. Registers keep their values.
- irq_o = IRQ & IE.

## Timing
- Outputs during reset and after release: ack_o=0, dat_o=0, irq_o=0, sda_o=1.
- Wishbone ack:
  - ack_o rises one clk_i after cyc_i&stb_i is sampled high, for exactly one cycle.
  - ack_o is never asserted on back-to-back cycles; the master must drop stb_i after ack_o.
  - Register writes take effect in the ack cycle. Read data is registered with ack.
- Write priority: if a Wishbone write-1-to-clear and a hardware set of IRQ or OVR land in the same cycle, the hardware set wins. A Wishbone RXD read coinciding with a new byte leaves RXV=1.
- SCL and SDA pass through a 2-flop synchronizer, so events lag the pins by 2 clk_i.
- SCL high and low phases must each be at least 8 clk_i. SDA output settles within 3 clk_i of the SCL fall.

## Configuration
- I2C_WB_IF_GLITCH_FILTER_EN defined: a 3-sample majority filter sits after the synchronizer on both SCL and SDA. Event latency becomes 4 clk_i, and single-cycle glitches are rejected.
- Not defined: synchronizer only, 2 clk_i latency, no filtering.

## Structure
- Package i2c_wb_if_pkg holds:
  - the FSM state enum
  - register address localparams (CSR=0, SADR=1, TXD=2, RXD=3)
  - CSR bit indices
  - reset constants (SADR_RST=8'h22)
- Sub-module i2c_wb_if_sync: synchronizer, optional filter, and SCL rise/fall and START/STOP pulse detection.

## Test plan
- Reset, then Wishbone read of all four registers -> 0x00, 0x22, 0x00, 0x00; sda_o=1; ack_o one cycle each.
- CSR=0xC0; master writes address 0x22 (W) then data 0x5A, then STOP:
  - ACK seen on both bytes
  - RXD=0x5A
  - CSR reads 0xD8: IRQ, RXV, EN and IE set
  - irq_o=1
- Write 1 to CSR[4] -> irq_o=0.
- TXD=0xA5; master reads address 0x22 (R) for two bytes (ACK then NACK) -> bus carries 0xA5 twice; after the NACK, SDA is released until STOP.
- Master addresses 0x23 -> no ACK (SDA stays 1), no IRQ, RXD unchanged.
- Two written bytes 0x11 then 0x22 without a Wishbone read between them -> RXD=0x22, OVR=1. Repeated START mid-write -> FSM re-enters ADDR and re-ACKs 0x22.
